// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master: FSM state encoding
// and the wire-order frame headers recognised by the optional header check.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

  localparam logic [31:0] HDR_DATA_WIRE  = 32'h61746164;
  localparam logic [31:0] HDR_ESTOP_WIRE = 32'h70747365;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// SPI bus pins between the master and a slave (or loopback) device.
interface spi_master_if;

  logic SPI_SCK;
  logic SPI_SSEL;
  logic SPI_MOSI;
  logic SPI_MISO;

  modport master (output SPI_SCK, output SPI_SSEL, output SPI_MOSI, input SPI_MISO);
  modport slave  (input SPI_SCK, input SPI_SSEL, input SPI_MOSI, output SPI_MISO);

endinterface

// File: rtl/spi_clkgen.sv
// SCK generator: half-period counter that toggles SCK on wrap while enabled,
// with strobes marking the clk cycle just before each SCK edge.
module spi_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic sample_pulse
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = en && (cnt == CNT_LAST);

  // Strobes are high in the cycle whose closing clk edge moves SCK, so the
  // last cycle of a high half is both the MISO sample point and the fall.
  assign rise_pulse   = wrap && !sck;
  assign fall_pulse   = wrap && sck;
  assign sample_pulse = wrap && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 frame master: sends tx_data MSB first while capturing MISO.
// Optional SPI_MASTER_HDR_CHECK_EN adds hdr_ok/hdr_estop header flags.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 240,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned GAP         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
`ifdef SPI_MASTER_HDR_CHECK_EN
  output logic                   hdr_ok,
  output logic                   hdr_estop,
`endif
  spi_master_if.master           spi
);

  localparam int unsigned BIT_W    = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned WAIT_MAX = max3(CS_SETUP, CS_HOLD, GAP);
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [BIT_W-1:0]  BIT_ALL    = BIT_W'(BUFFER_SIZE);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP - 1);

  spi_state_e             state, state_next;
  logic [BUFFER_SIZE-1:0] shift, shift_next;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_next;
  logic [WAIT_W-1:0]      wait_cnt, wait_cnt_next;
  logic                   frame_end;
  logic                   xfer_en;
  logic                   sck, rise_pulse, fall_pulse, sample_pulse;
  logic                   ssel, mosi;

  assign xfer_en = (state == spi_pkg::XFER);

  spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (xfer_en),
    .sck          (sck),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .sample_pulse (sample_pulse)
  );

  always_comb begin
    state_next    = state;
    shift_next    = shift;
    bit_cnt_next  = bit_cnt;
    wait_cnt_next = wait_cnt;
    frame_end     = 1'b0;
    case (state)
      spi_pkg::IDLE: begin
        if (start) begin
          shift_next    = tx_data;
          bit_cnt_next  = '0;
          wait_cnt_next = '0;
          state_next    = spi_pkg::SETUP;
        end
      end
      spi_pkg::SETUP: begin
        if (wait_cnt == SETUP_LAST) begin
          wait_cnt_next = '0;
          state_next    = spi_pkg::XFER;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      spi_pkg::XFER: begin
        if (rise_pulse) bit_cnt_next = bit_cnt + 1'b1;
        // Sampling into the LSB and shifting toward MOSI share one cycle.
        if (sample_pulse) shift_next = {shift[BUFFER_SIZE-2:0], spi.SPI_MISO};
        if (fall_pulse && (bit_cnt == BIT_ALL)) state_next = spi_pkg::HOLD;
      end
      spi_pkg::HOLD: begin
        if (wait_cnt == HOLD_LAST) begin
          wait_cnt_next = '0;
          frame_end     = 1'b1;
          state_next    = spi_pkg::GAP;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      spi_pkg::GAP: begin
        if (wait_cnt == GAP_LAST) begin
          wait_cnt_next = '0;
          state_next    = spi_pkg::IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      default: state_next = spi_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= spi_pkg::IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ssel     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      wait_cnt <= wait_cnt_next;
      done     <= frame_end;
      if (frame_end) rx_data <= shift;
      busy     <= (state_next != spi_pkg::IDLE);
      ssel     <= !(state_next inside {spi_pkg::SETUP, spi_pkg::XFER, spi_pkg::HOLD});
      mosi     <= (state_next inside {spi_pkg::SETUP, spi_pkg::XFER}) ?
                  shift_next[BUFFER_SIZE-1] : 1'b0;
    end
  end

  assign spi.SPI_SCK  = sck;
  assign spi.SPI_SSEL = ssel;
  assign spi.SPI_MOSI = mosi;

`ifdef SPI_MASTER_HDR_CHECK_EN
  logic [31:0] hdr_word;

  // Frames shorter than a header can never carry one.
  if (BUFFER_SIZE >= 32) begin : g_hdr
    assign hdr_word = shift[BUFFER_SIZE-1 -: 32];
  end else begin : g_hdr_short
    assign hdr_word = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_ok    <= 1'b0;
      hdr_estop <= 1'b0;
    end else if (frame_end) begin
      hdr_ok    <= (hdr_word == HDR_DATA_WIRE);
      hdr_estop <= (hdr_word == HDR_ESTOP_WIRE);
    end
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (16-bit frames, CLK_DIV=2) with a mode-0 slave model;
// header flags are exercised on a 240-bit instance when SPI_MASTER_HDR_CHECK_EN is set.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst_n, start, loop;
  logic [15:0] tx_data, rx_data;
  logic        busy, done;
  logic [15:0] slave_val, slave_tx, slave_rx;
  logic        sck_d;
  int          errors = 0;
  int          checks = 0;
  int          rise_cnt = 0;
  int          ssel_low = 0;
  int          done_cnt = 0;
  int          cyc, n, r0, s0, d0;

  spi_master_if spi();

`ifdef SPI_MASTER_HDR_CHECK_EN
  logic hdr_ok16, hdr_estop16;
`endif

  spi_master #(
    .BUFFER_SIZE (16),
    .CLK_DIV     (2),
    .CS_SETUP    (2),
    .CS_HOLD     (2),
    .GAP         (4)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
`ifdef SPI_MASTER_HDR_CHECK_EN
    .hdr_ok    (hdr_ok16),
    .hdr_estop (hdr_estop16),
`endif
    .spi     (spi)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: loads its word while deselected, captures MOSI on SCK rise,
  // shifts its output on SCK fall.
  initial begin
    slave_tx = '0;
    slave_rx = '0;
    sck_d    = 1'b0;
  end
  always @(posedge clk) begin
    sck_d <= spi.SPI_SCK;
    if (spi.SPI_SSEL) slave_tx <= slave_val;
    else if (sck_d && !spi.SPI_SCK) slave_tx <= {slave_tx[14:0], 1'b0};
    if (!spi.SPI_SSEL && !sck_d && spi.SPI_SCK) slave_rx <= {slave_rx[14:0], spi.SPI_MOSI};
  end

  assign spi.SPI_MISO = loop ? spi.SPI_MOSI : slave_tx[15];

  always @(posedge spi.SPI_SCK) rise_cnt++;
  always @(posedge clk) begin
    if (!spi.SPI_SSEL) ssel_low++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] d);
    tx_data = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 2000) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
  endtask

`ifdef SPI_MASTER_HDR_CHECK_EN
  logic [239:0] tx240, rx240;
  logic         start240, busy240, done240, hdr_ok, hdr_estop;
  spi_master_if spi240();
  assign spi240.SPI_MISO = spi240.SPI_MOSI;

  spi_master #(
    .BUFFER_SIZE (240),
    .CLK_DIV     (2),
    .CS_SETUP    (2),
    .CS_HOLD     (2),
    .GAP         (4)
  ) u_dut240 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start240),
    .tx_data   (tx240),
    .rx_data   (rx240),
    .busy      (busy240),
    .done      (done240),
    .hdr_ok    (hdr_ok),
    .hdr_estop (hdr_estop),
    .spi       (spi240)
  );

  task automatic hdr_frame(input logic [31:0] w, input logic exp_ok, input logic exp_estop);
    int c;
    tx240    = {w, 208'h0};
    start240 = 1'b1;
    tick();
    start240 = 1'b0;
    c = 1;
    while (!done240 && c < 3000) begin
      tick();
      c++;
    end
    chk("hdr_done_cycle", c, 965);
    chk("hdr_rx_top", rx240[239:208], w);
    chk("hdr_ok", hdr_ok, exp_ok);
    chk("hdr_estop", hdr_estop, exp_estop);
    c = 0;
    while (busy240 && c < 200) begin
      tick();
      c++;
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tx_data   = '0;
    loop      = 1'b1;
    slave_val = '0;
`ifdef SPI_MASTER_HDR_CHECK_EN
    start240  = 1'b0;
    tx240     = '0;
`endif
    repeat (3) tick();

    chk("rst_ssel", spi.SPI_SSEL, 1);
    chk("rst_sck", spi.SPI_SCK, 0);
    chk("rst_mosi", spi.SPI_MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);

    rst_n = 1'b1;
    r0 = rise_cnt;
    s0 = ssel_low;
    repeat (100) tick();
    chk("idle_rises", rise_cnt - r0, 0);
    chk("idle_ssel_low", ssel_low - s0, 0);
    chk("idle_busy", busy, 0);

    // Loopback 16'hA55A
    loop = 1'b1;
    r0 = rise_cnt;
    s0 = ssel_low;
    pulse_start(16'hA55A);
    chk("lb_busy_c1", busy, 1);
    chk("lb_ssel_c1", spi.SPI_SSEL, 0);
    chk("lb_rx_hold", rx_data, 0);
    wait_done(cyc);
    chk("lb_done_cycle", cyc, 69);
    chk("lb_rx", rx_data, 16'hA55A);
    chk("lb_rises", rise_cnt - r0, 16);
    chk("lb_ssel_low", ssel_low - s0, 68);
    chk("lb_busy_done", busy, 1);
    tick();
    chk("lb_done_width", done, 0);
    wait_idle(n);
    chk("lb_gap_to_idle", n, 3);

    // Slave model returns 16'h1234, master sends 16'hFFFF
    loop = 1'b0;
    slave_val = 16'h1234;
    tick();
    r0 = rise_cnt;
    s0 = ssel_low;
    pulse_start(16'hFFFF);
    wait_done(cyc);
    chk("sl_done_cycle", cyc, 69);
    chk("sl_rx", rx_data, 16'h1234);
    chk("sl_slave_rx", slave_rx, 16'hFFFF);
    chk("sl_ssel_low", ssel_low - s0, 68);
    chk("sl_rises", rise_cnt - r0, 16);
    wait_idle(n);

    // start held high throughout; tx_data changes after acceptance
    slave_val = 16'hBEEF;
    tick();
    r0 = rise_cnt;
    d0 = done_cnt;
    tx_data = 16'h0F0F;
    start = 1'b1;
    tick();
    tx_data = 16'hFFFF;
    wait_done(cyc);
    chk("rp_done_cycle", cyc, 69);
    chk("rp_rx", rx_data, 16'hBEEF);
    chk("rp_slave_rx", slave_rx, 16'h0F0F);
    chk("rp_rises", rise_cnt - r0, 16);
    n = 0;
    while (spi.SPI_SSEL && n < 50) begin
      tick();
      n++;
    end
    chk("rp_done_to_ssel_fall", n, 5);
    chk("rp_done_count", done_cnt - d0, 1);
    start = 1'b0;
    wait_done(cyc);
    wait_idle(n);

    // Reset asserted mid-frame after the 5th SCK rise
    loop = 1'b1;
    r0 = rise_cnt;
    pulse_start(16'h3C96);
    n = 0;
    while ((rise_cnt - r0) < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("mr_reached_5_rises", rise_cnt - r0, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ssel", spi.SPI_SSEL, 1);
    chk("mr_sck", spi.SPI_SCK, 0);
    chk("mr_mosi", spi.SPI_MOSI, 0);
    chk("mr_rx", rx_data, 0);
    chk("mr_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    loop = 1'b0;
    slave_val = 16'hC3A5;
    tick();
    r0 = rise_cnt;
    s0 = ssel_low;
    pulse_start(16'h5AC3);
    wait_done(cyc);
    chk("mr2_done_cycle", cyc, 69);
    chk("mr2_rx", rx_data, 16'hC3A5);
    chk("mr2_slave_rx", slave_rx, 16'h5AC3);
    chk("mr2_rises", rise_cnt - r0, 16);
    chk("mr2_ssel_low", ssel_low - s0, 68);
    wait_idle(n);

`ifdef SPI_MASTER_HDR_CHECK_EN
    hdr_frame(32'h61746164, 1'b1, 1'b0);
    hdr_frame(32'h70747365, 1'b0, 1'b1);
    hdr_frame(32'h00000000, 1'b0, 1'b0);
    chk("hdr16_ok", hdr_ok16, 0);
    chk("hdr16_estop", hdr_estop16, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
